adder_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one external combinational W-bit adder (5-bit sum for W=4) between N requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the shared adder from registered operands.
- Captures the W+1-bit sum and returns it, tagged with the requester id, over a single response handshake with backpressure.
- Sits between the operand producers and the adder instance in the datapath.

---
 rtl/adder_arbiter.sv | 119 +++++++++++
 tb/tb_adder_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sequencer sharing one external W-bit adder among N requesters
// Define ADDER_ARB_OVF_CNT_EN to add ovf_count, a saturating count of sums with carry out.
module adder_arbiter #(
    parameter int W   = 4,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   req_ready,
    output logic [W-1:0]   add_inA,
    output logic [W-1:0]   add_inB,
    input  logic [W:0]     add_out,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [W:0]     rsp_sum,
`ifdef ADDER_ARB_OVF_CNT_EN
    output logic [7:0]     ovf_count,
`endif
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         state_q;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   op_a_q, op_b_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W:0]     rsp_sum_q;
    logic           rsp_valid_q;
`ifdef ADDER_ARB_OVF_CNT_EN
    logic [7:0]     ovf_count_q;
`endif

    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic [W-1:0]   gnt_a, gnt_b;

    // Walk from the farthest candidate back toward rr_ptr so the nearest valid one wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        rr_ptr_d  = rr_ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(idx);
                gnt_a     = req_a[idx*W +: W];
                gnt_b     = req_b[idx*W +: W];
                rr_ptr_d  = IDW'((idx + 1) % N);
            end
        end
    end

    assign req_ready = (rst_n && (state_q == IDLE) && gnt_found) ? (N'(1) << gnt_id) : '0;
    assign add_inA   = op_a_q;
    assign add_inB   = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (state_q != IDLE);
`ifdef ADDER_ARB_OVF_CNT_EN
    assign ovf_count = ovf_count_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_valid_q <= 1'b0;
`ifdef ADDER_ARB_OVF_CNT_EN
            ovf_count_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        op_a_q   <= gnt_a;
                        op_b_q   <= gnt_b;
                        rsp_id_q <= gnt_id;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum_q   <= add_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
`ifdef ADDER_ARB_OVF_CNT_EN
                    if (add_out[W] && (ovf_count_q != 8'hFF)) begin
                        ovf_count_q <= ovf_count_q + 8'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed and random checks of adder_arbiter against a transaction-level model
module tb_adder_arbiter;
    localparam int W   = 4;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '1;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   add_inA, add_inB;
    logic [W:0]     add_out;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [W:0]     rsp_sum;
    logic           busy;
`ifdef ADDER_ARB_OVF_CNT_EN
    logic [7:0]     ovf_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: one outstanding operation, described by its operands and age.
    bit m_busy = 0;
    int m_age  = 0;
    int m_rr   = 0;
    int m_a    = 0;
    int m_b    = 0;
    int m_id   = 0;
    int m_ovf  = 0;
    int dut_grants[$];

    always #5 clk = ~clk;

    assign add_out = {1'b0, add_inA} + {1'b0, add_inB};

    adder_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_inA   (add_inA),
        .add_inB   (add_inB),
        .add_out   (add_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
`ifdef ADDER_ARB_OVF_CNT_EN
        .ovf_count (ovf_count),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] pack(input int f0, input int f1, input int f2, input int f3);
        return {W'(f3), W'(f2), W'(f1), W'(f0)};
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input logic rr);
        int g;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        if (req_ready != '0) dut_grants.push_back($clog2(req_ready));
`ifdef ADDER_ARB_OVF_CNT_EN
        check("ovf_count", ovf_count, m_ovf);
`endif
        if (!m_busy) begin
            g = winner(v, m_rr);
            check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
            check("busy_idle", busy, 0);
            check("rsp_valid_idle", rsp_valid, 0);
            if (g >= 0) begin
                m_a    = int'(a[g*W +: W]);
                m_b    = int'(b[g*W +: W]);
                m_id   = g;
                m_rr   = (g + 1) % N;
                m_busy = 1;
                m_age  = 0;
            end
        end else begin
            check("req_ready_busy", req_ready, 0);
            check("busy", busy, 1);
            check("add_inA", add_inA, m_a);
            check("add_inB", add_inB, m_b);
            if (m_age == 0) begin
                check("rsp_valid_calc", rsp_valid, 0);
                m_age = 1;
                if ((m_a + m_b) >= (1 << W) && m_ovf < 255) m_ovf++;
            end else begin
                check("rsp_valid", rsp_valid, 1);
                check("rsp_id", rsp_id, m_id);
                check("rsp_sum", rsp_sum, m_a + m_b);
                if (rr) m_busy = 0;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_add_inA", add_inA, 0);
        check("rst_add_inB", add_inB, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_req_ready", req_ready, 0);
        m_busy = 0;
        m_rr   = 0;
        m_ovf  = 0;
`ifdef ADDER_ARB_OVF_CNT_EN
        check("rst_ovf_count", ovf_count, 0);
`endif
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    initial begin
        logic [N*W-1:0] ra, rb;

        pulse_reset();

        // All four requesters contending, response always accepted.
        dut_grants.delete();
        for (int op = 0; op < 5; op++) begin
            for (int s = 0; s < 3; s++) begin
                step(4'b1111, pack(7, 1, 4, 9), pack(6, 2, 8, 6), 1'b1);
            end
            if (op == 0) check("rr_first_sum", rsp_sum, 13);
        end
        check("rr_count", dut_grants.size(), 5);
        for (int i = 0; i < 5 && i < dut_grants.size(); i++) begin
            check("rr_order", dut_grants[i], i % N);
        end

        // Single request from requester 1 (rr pointer now at 1).
        dut_grants.delete();
        step(4'b0010, pack(0, 2, 0, 0), pack(0, 3, 0, 0), 1'b1);
        check("single_ready", req_ready, 4'b0010);
        step(4'b0000, '0, '0, 1'b1);
        step(4'b0000, '0, '0, 1'b1);
        check("single_valid", rsp_valid, 1);
        check("single_id", rsp_id, 1);
        check("single_sum", rsp_sum, 5'b00101);
        step(4'b0000, '0, '0, 1'b1);

        // Max operands produce a carry out.
        step(4'b1000, pack(0, 0, 0, 15), pack(0, 0, 0, 15), 1'b1);
        step(4'b0000, '0, '0, 1'b1);
        step(4'b0000, '0, '0, 1'b1);
        check("max_sum", rsp_sum, 5'b11110);
`ifdef ADDER_ARB_OVF_CNT_EN
        check("max_ovf", ovf_count, 1);
`endif

        // Backpressure for five response cycles with all requesters waiting.
        step(4'b1111, pack(3, 5, 9, 12), pack(4, 11, 9, 2), 1'b0);
        for (int i = 0; i < 6; i++) step(4'b1111, pack(3, 5, 9, 12), pack(4, 11, 9, 2), 1'b0);
        step(4'b1111, pack(3, 5, 9, 12), pack(4, 11, 9, 2), 1'b1);
        for (int i = 0; i < 3; i++) step(4'b1111, pack(3, 5, 9, 12), pack(4, 11, 9, 2), 1'b1);

        // Reset while the operation is in CALC; requester 0 must win afterwards.
        step(4'b1111, pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1);
        if (m_busy && m_age == 0) step(4'b1111, pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1);
        while (m_busy) step(4'b0000, '0, '0, 1'b1);
        step(4'b1111, pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1);
        pulse_reset();
        dut_grants.delete();
        step(4'b1111, pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1);
        check("post_reset_grant", (dut_grants.size() > 0) ? dut_grants[0] : 99, 0);
        step(4'b0000, '0, '0, 1'b1);
        step(4'b0000, '0, '0, 1'b1);
        step(4'b0000, '0, '0, 1'b1);

        // Requester 2 alone, then 2 and 3: 3 must be served before 2 again.
        pulse_reset();
        dut_grants.delete();
        step(4'b0100, pack(0, 0, 6, 0), pack(0, 0, 1, 0), 1'b1);
        step(4'b1100, pack(0, 0, 6, 9), pack(0, 0, 1, 9), 1'b1);
        step(4'b1100, pack(0, 0, 6, 9), pack(0, 0, 1, 9), 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1100, pack(0, 0, 6, 9), pack(0, 0, 1, 9), 1'b1);
        check("pair_count", dut_grants.size(), 3);
        check("pair_g0", (dut_grants.size() > 0) ? dut_grants[0] : 99, 2);
        check("pair_g1", (dut_grants.size() > 1) ? dut_grants[1] : 99, 3);
        check("pair_g2", (dut_grants.size() > 2) ? dut_grants[2] : 99, 2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            step(N'($urandom), ra, rb, ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
